// File: rtl/intersection_cmd_sequencer_if.sv
// Sensor-event payload type and the valid/ready event bus into the command sequencer.

package intersection_cmd_pkg;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned PLATE_W = 5;

  typedef struct packed {
    logic [TYPE_W-1:0]  kind;
    logic [PLATE_W-1:0] plate;
  } evt_t;
endpackage

interface intersection_cmd_if;
  import intersection_cmd_pkg::*;

  logic               evt_valid;
  logic               evt_ready;
  logic [TYPE_W-1:0]  evt_type;
  logic [PLATE_W-1:0] evt_plate;

  modport master (output evt_valid, output evt_type, output evt_plate, input evt_ready);
  modport slave  (input evt_valid, input evt_type, input evt_plate, output evt_ready);
endinterface

// File: rtl/intersection_cmd_sequencer.sv
// Buffers road sensor events and replays them as setup/pulse/hold command
// sequences; blacklist display requests are only granted between commands.

module intersection_cmd_sequencer
  import intersection_cmd_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  intersection_cmd_if.slave   evt,
  input  logic                disp_req,
  output logic [2:0]          mode,
  output logic [PLATE_W-1:0]  plateIn,
  output logic                action,
  output logic [AW:0]         fifo_count,
  output logic                busy,
  output logic [7:0]          drop_cnt,
  output logic                overflow
);

  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DISP
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         mode_d;
  logic [PLATE_W-1:0] plate_d;
  logic               action_d;
  logic               busy_d;
  logic               pop;
  logic               push;
  logic               drop;

  evt_t               mem [DEPTH];
  evt_t               head;
  logic [AW-1:0]      wr_ptr, rd_ptr;

  assign evt.evt_ready = (fifo_count != CNTW'(DEPTH));
  assign push          = evt.evt_valid && evt.evt_ready;
  assign drop          = evt.evt_valid && !evt.evt_ready;
  assign head          = mem[rd_ptr];

  // Storage array needs no reset; validity is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{kind: evt.evt_type, plate: evt.evt_plate};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode    <= '0;
      plateIn <= '0;
      action  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode    <= mode_d;
      plateIn <= plate_d;
      action  <= action_d;
      busy    <= busy_d;
    end
  end

  // Outputs are computed for the next state so they leave the flops glitch-free.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode;
    plate_d  = plateIn;
    action_d = 1'b0;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mode_d = 3'b000;
        if (disp_req) begin
          state_d = ST_DISP;
          mode_d  = 3'b100;
        end else if (fifo_count != '0) begin
          pop     = 1'b1;
          mode_d  = {1'b0, head.kind};
          plate_d = head.plate;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC)) begin
          state_d  = ST_PULSE;
          cnt_d    = '0;
          action_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          action_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mode_d  = 3'b000;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DISP: begin
        mode_d = 3'b100;
        if (!disp_req) begin
          state_d = ST_IDLE;
          mode_d  = 3'b000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mode_d  = 3'b000;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule
